// File: rtl/e_mdu_pkg.sv
// Shared MDU op codes and decode helpers for the E-stage multiply/divide unit.
// Optional MADD/MSUB family is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for ops that occupy the unit for a multi-cycle run.
    function automatic logic is_md_start(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Request/response bundle between the E-stage controller and the MDU.
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] md_rdata;

    modport master (
        output start, mdu_op, src_a, src_b,
        input  busy, md_rdata
    );

    modport slave (
        input  start, mdu_op, src_a, src_b,
        output busy, md_rdata
    );
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational 64-bit HI/LO result for an MDU op; wr_en low means keep HI/LO.
// MDU_MADD_EN adds the accumulate/subtract family.
module e_mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        wr_en
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] acc;
    logic        [63:0] res;
    logic        [31:0] b_safe;
    logic        [31:0] q_s, r_s, q_u, r_u;
    logic               div_ovf;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign acc    = {hi, lo};

    // Dividing by 1 for b==0 or MIN/-1 keeps the divider well defined;
    // MIN/1 already yields the required LO=MIN, HI=0 for the overflow case.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_safe  = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
    assign q_s     = $signed(a) / $signed(b_safe);
    assign r_s     = $signed(a) % $signed(b_safe);
    assign q_u     = a / b_safe;
    assign r_u     = a % b_safe;

    always_comb begin
        res   = acc;
        wr_en = 1'b0;
        case (op)
            MDU_MULT:  begin res = prod_s;       wr_en = 1'b1;        end
            MDU_MULTU: begin res = prod_u;       wr_en = 1'b1;        end
            MDU_DIV:   begin res = {r_s, q_s};   wr_en = (b != 32'd0); end
            MDU_DIVU:  begin res = {r_u, q_u};   wr_en = (b != 32'd0); end
`ifdef MDU_MADD_EN
            MDU_MADD:  begin res = acc + prod_s; wr_en = 1'b1;        end
            MDU_MADDU: begin res = acc + prod_u; wr_en = 1'b1;        end
            MDU_MSUB:  begin res = acc - prod_s; wr_en = 1'b1;        end
            MDU_MSUBU: begin res = acc - prod_u; wr_en = 1'b1;        end
`endif
            default:   begin res = acc;          wr_en = 1'b0;        end
        endcase
    end

    assign {hi_res, lo_res} = res;
endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: busy counter, pending result and committed HI/LO.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU as start-class ops.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      hi, lo;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_we;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_we;
    logic             capture, commit, mthi_we, mtlo_we;

    e_mdu_calc u_calc (
        .op     (bus.mdu_op),
        .a      (bus.src_a),
        .b      (bus.src_b),
        .hi     (hi),
        .lo     (lo),
        .hi_res (calc_hi),
        .lo_res (calc_lo),
        .wr_en  (calc_we)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        commit    = 1'b0;
        mthi_we   = 1'b0;
        mtlo_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A forced start suppresses any concurrent mthi/mtlo.
                if (bus.start) begin
                    if (is_md_start(bus.mdu_op)) begin
                        capture   = 1'b1;
                        cnt_nxt   = is_div_class(bus.mdu_op) ? CNT_W'(DIV_CYCLES)
                                                             : CNT_W'(MULT_CYCLES);
                        state_nxt = ST_BUSY;
                    end
                end else begin
                    mthi_we = (bus.mdu_op == MDU_MTHI);
                    mtlo_we = (bus.mdu_op == MDU_MTLO);
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
                pend_we <= calc_we;
            end
            if (commit) begin
                if (pend_we) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end else begin
                if (mthi_we) hi <= bus.src_a;
                if (mtlo_we) lo <= bus.src_a;
            end
        end
    end

    assign bus.busy     = (state == ST_BUSY);
    assign bus.md_rdata = (bus.mdu_op == MDU_MFHI) ? hi :
                          (bus.mdu_op == MDU_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected reads and busy lengths,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] m_hi, m_lo;
    logic [31:0] rd_q[$];
    int          blen_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    function automatic bit tb_is_madd(input logic [3:0] op);
        return op == MDU_MADD || op == MDU_MADDU || op == MDU_MSUB || op == MDU_MSUBU;
    endfunction

    function automatic bit tb_is_start(input logic [3:0] op);
        bit s;
        s = (op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU);
`ifdef MDU_MADD_EN
        s = s || tb_is_madd(op);
`endif
        return s;
    endfunction

    // Reference behaviour from the arithmetic definitions (sign/magnitude division).
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo,
                             output logic [31:0] nhi, output logic [31:0] nlo);
        longint          sa, sb, ma, mb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        acc = {hi, lo};
        {nhi, nlo} = acc;
        case (op)
            MDU_MULT:  {nhi, nlo} = sa * sb;
            MDU_MULTU: {nhi, nlo} = ua * ub;
            MDU_DIV: if (b != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = ma / mb;
                r = ma % mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                nlo = q[31:0];
                nhi = r[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                nlo = a / b;
                nhi = a % b;
            end
            MDU_MADD:  begin p = sa * sb; {nhi, nlo} = acc + p; end
            MDU_MADDU: begin p = ua * ub; {nhi, nlo} = acc + p; end
            MDU_MSUB:  begin p = sa * sb; {nhi, nlo} = acc - p; end
            MDU_MSUBU: begin p = ua * ub; {nhi, nlo} = acc - p; end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        bus.mdu_op = op;
        bus.start  = st;
        bus.src_a  = a;
        bus.src_b  = b;
        if (op == MDU_MFHI) rd_q.push_back(m_hi);
        if (op == MDU_MFLO) rd_q.push_back(m_lo);
        @(posedge clk);
        #1;
        bus.mdu_op = MDU_NONE;
        bus.start  = 1'b0;
    endtask

    task automatic reads();
        cyc(MDU_MFHI, 1'b0, 32'd0, 32'd0);
        cyc(MDU_MFLO, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        cyc(op, 1'b0, a, 32'd0);
        if (op == MDU_MTHI) m_hi = a;
        if (op == MDU_MTLO) m_lo = a;
    endtask

    // Activity while busy: must all be ignored, reads must show committed values.
    task automatic busy_cyc(input int idx);
        int k;
        k = (idx == 0) ? 3 : (idx == 1) ? 1 : $urandom_range(0, 4);
        case (k)
            0: cyc(MDU_MFHI, 1'b0, 32'd0, 32'd0);
            1: cyc(MDU_MFLO, 1'b0, 32'd0, 32'd0);
            2: cyc(MDU_MTHI, 1'b0, $urandom, 32'd0);
            3: cyc(MDU_MTLO, 1'b0, (idx == 0) ? 32'd5 : $urandom, 32'd0);
            default: cyc(4'($urandom_range(1, 12)), 1'b1, $urandom, $urandom);
        endcase
    endtask

    task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int abort_after);
        int n;
        logic [31:0] nhi, nlo;
        if (!tb_is_start(op)) begin
            cyc(op, 1'b1, a, b);
            return;
        end
        n = (op == MDU_DIV || op == MDU_DIVU) ? DC : MC;
        ref_model(op, a, b, m_hi, m_lo, nhi, nlo);
        blen_q.push_back((abort_after >= 0) ? abort_after + 1 : n);
        cyc(op, 1'b1, a, b);
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) busy_cyc(i);
            reset = 1'b1;
            cyc(MDU_NONE, 1'b0, 32'd0, 32'd0);
            reset = 1'b0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            for (int i = 0; i < n; i++) busy_cyc(i);
            m_hi = nhi;
            m_lo = nlo;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard
    initial begin
        int run;
        int exp_len;
        logic [31:0] exp_rd;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.mdu_op == MDU_MFHI || bus.mdu_op == MDU_MFLO) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got %h, required no read", bus.md_rdata);
                end else begin
                    exp_rd = rd_q.pop_front();
                    if (bus.md_rdata !== exp_rd) begin
                        errors++;
                        $display("FAIL md_rdata op=%0d t=%0t: got %h, required %h",
                                 bus.mdu_op, $time, bus.md_rdata, exp_rd);
                    end
                end
            end
            if (bus.busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                checks++;
                if (blen_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_unexpected: got %0d busy cycles, required 0", run);
                end else begin
                    exp_len = blen_q.pop_front();
                    if (run != exp_len) begin
                        errors++;
                        $display("FAIL busy_len t=%0t: got %0d, required %0d", $time, run, exp_len);
                    end
                end
                run = 0;
            end
            if (blen_q.size() == 0 && run == 0 && !reset) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy t=%0t: got %b, required 0", $time, bus.busy);
                end
            end
            if (done) begin
                checks++;
                if (rd_q.size() != 0 || blen_q.size() != 0 || run != 0) begin
                    errors++;
                    $display("FAIL drain: got rd=%0d busy=%0d run=%0d, required all 0",
                             rd_q.size(), blen_q.size(), run);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [3:0] op;
        bus.start  = 1'b0;
        bus.mdu_op = MDU_NONE;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        reads();

        do_start(MDU_MULT,  32'hFFFF_FFFF, 32'd2, -1);  reads();
        do_start(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, -1);  reads();
        do_start(MDU_DIV,   32'hFFFF_FFF9, 32'd2, -1);  reads();
        do_start(MDU_DIVU,  32'd7,         32'd2, -1);  reads();
        mt(MDU_MTHI, 32'h1234);
        do_start(MDU_DIVU,  32'd99,        32'd0, -1);  reads();
        do_start(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1); reads();
        do_start(MDU_MULT,  32'h1000,      32'd3, -1);  reads();
        do_start(MDU_DIV,   32'd100,       32'd7, 3);   reads();
        mt(MDU_MTLO, 32'd10);
        mt(MDU_MTHI, 32'd0);
        do_start(MDU_MADD,  32'd3,         32'd4, -1);  reads();

        for (int it = 0; it < 60; it++) begin
            op = 4'($urandom_range(1, 12));
            if (op == MDU_MTHI || op == MDU_MTLO) mt(op, rand_operand());
            else if (op == MDU_MFHI || op == MDU_MFLO) cyc(op, 1'b0, 32'd0, 32'd0);
            else do_start(op, rand_operand(), rand_operand(), -1);
            reads();
        end
        repeat (2) cyc(MDU_NONE, 1'b0, 32'd0, 32'd0);
        done = 1'b1;
    end
endmodule
